// File: rtl/bit_serializer.sv
// bit_serializer: W-bit parallel word to 1 bit/cycle stream, valid/ready in.
// Ports: din/din_valid/din_ready in, flush abort, dout/dout_valid/dout_last out.
module bit_serializer #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   input  logic         flush,
   output logic         dout,
   output logic         dout_valid,
   output logic         dout_last
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [W-1:0]   sreg, sreg_n;
   logic           dout_n, vld_n, last_n;
   logic           xfer, at_end;

   // cnt is the shift-order index of the bit currently on dout
   assign at_end    = (cnt == LAST);
   assign din_ready = !rst && !flush && (state == IDLE || at_end);
   assign xfer      = din_valid && din_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sreg       <= '0;
         dout       <= IDLE_BIT;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         sreg       <= sreg_n;
         dout       <= dout_n;
         dout_valid <= vld_n;
         dout_last  <= last_n;
      end
   end

   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    if (xfer) state_n = SHIFT;
            SHIFT:   if (at_end && !xfer) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // sreg holds only the bits not yet shown; the first bit
   // goes straight from din to the dout register on load.
   always_comb begin
      cnt_n  = cnt;
      sreg_n = sreg;
      dout_n = IDLE_BIT;
      vld_n  = 1'b0;
      last_n = 1'b0;
      if (flush) begin
         cnt_n = '0;
      end else if (xfer) begin
         cnt_n = '0;
         vld_n = 1'b1;
         if (MSB_FIRST) begin
            dout_n = din[W-1];
            sreg_n = {din[W-2:0], 1'b0};
         end else begin
            dout_n = din[0];
            sreg_n = {1'b0, din[W-1:1]};
         end
      end else if (state == SHIFT && !at_end) begin
         cnt_n  = cnt + 1'b1;
         vld_n  = 1'b1;
         last_n = (cnt_n == LAST);
         if (MSB_FIRST) begin
            dout_n = sreg[W-1];
            sreg_n = {sreg[W-2:0], 1'b0};
         end else begin
            dout_n = sreg[0];
            sreg_n = {1'b0, sreg[W-1:1]};
         end
      end else begin
         cnt_n = '0;
      end
   end

endmodule
